// File: rtl/pp_col_serializer.sv
// ---------------------------------------------------------------------------
// pp_col_serializer
//
// Partial-product serializer for the cascade multiplier test path. An operand
// pair (a, b) is accepted over a valid/ready handshake. The N x N AND-array
// partial products are then streamed, one bit per column per cycle, into the
// downstream per-column shift registers that feed the compressor. Column k
// has depth d(k) = k+1 for k <= N-1 and 2N-1-k for k >= N. After N shift
// cycles those registers hold the complete array, and frame_done marks the
// single cycle in which the compressor outputs equal a*b.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     operand pair on in_a/in_b is valid
//   in_a, in_b   N-bit unsigned multiplicand / multiplier
//   in_ready     block can accept an operand pair this cycle
//   pp_col       registered serial bit per column (column k -> src{k}_)
//   busy         high while shifting
//   frame_done   downstream registers hold the full array this cycle
//   exp_product  reference product a*b (2N bits)
//
// Optional feature macro: PP_COL_SERIALIZER_CHECK_EN
//   defined   : a*b is registered into exp_product at acceptance and held
//               until the next acceptance or reset
//   undefined : no multiplier is built; exp_product is tied to 0
// ---------------------------------------------------------------------------
module pp_col_serializer #(
  parameter int N = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             in_ready,
  output logic [2*N-2:0]   pp_col,
  output logic             busy,
  output logic             frame_done,
  output logic [2*N-1:0]   exp_product
);

  localparam int TW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [N-1:0]   op_a_q, op_a_d;
  logic [N-1:0]   op_b_q, op_b_d;
  logic [2*N-2:0] pp_col_q, pp_col_d;
  logic           accept;

  // Bit that column k carries in shift step t. Bits enter late (zeros first)
  // so that after the final shift every bit sits at its aligned position and
  // none has been pushed out of the column's d(k)-deep register.
  function automatic logic col_bit(input int k, input int t,
                                   input logic [N-1:0] a,
                                   input logic [N-1:0] b);
    int d;
    int m;
    logic [N-1:0] a_sh;
    logic [N-1:0] b_sh;
    d = (k <= N-1) ? (k + 1) : (2*N - 1 - k);
    if (t < N - d) begin
      return 1'b0;
    end
    m = t - (N - d);
    if (k <= N-1) begin
      a_sh = a >> m;
      b_sh = b >> (k - m);
    end else begin
      a_sh = a >> (k - N + 1 + m);
      b_sh = b >> (N - 1 - m);
    end
    return a_sh[0] & b_sh[0];
  endfunction

  assign in_ready   = (state_q != S_SHIFT);
  assign busy       = (state_q == S_SHIFT);
  assign frame_done = (state_q == S_DONE);
  assign pp_col     = pp_col_q;
  assign accept     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    case (state_q)
      // DONE behaves like IDLE for acceptance, which gives back-to-back frames.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        t_d     = '0;
        if (accept) begin
          state_d = S_SHIFT;
          op_a_d  = in_a;
          op_b_d  = in_b;
        end
      end
      S_SHIFT: begin
        if (t_q == TW'(N-1)) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // pp_col is computed from the next state so the registered output shows
  // step t's bits during the cycle in which the counter reads t.
  always_comb begin
    pp_col_d = '0;
    if (state_d == S_SHIFT) begin
      for (int k = 0; k < 2*N-1; k++) begin
        pp_col_d[k] = col_bit(k, int'(t_d), op_a_d, op_b_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      pp_col_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      pp_col_q <= pp_col_d;
    end
  end

`ifdef PP_COL_SERIALIZER_CHECK_EN
  logic [2*N-1:0] exp_product_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_product_q <= '0;
    end else if (accept) begin
      exp_product_q <= (2*N)'(in_a) * (2*N)'(in_b);
    end
  end

  assign exp_product = exp_product_q;
`else
  assign exp_product = '0;
`endif

endmodule

// File: tb/tb_pp_col_serializer.sv
module tb_pp_col_serializer;

  localparam int N = 27;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_ready;
  logic [2*N-2:0]   pp_col;
  logic             busy;
  logic             frame_done;
  logic [2*N-1:0]   exp_product;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Downstream per-column shift registers (shift every clock).
  logic           mdl_clr;
  logic [N-1:0]   colreg [2*N-1];

  pp_col_serializer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_ready    (in_ready),
    .pp_col      (pp_col),
    .busy        (busy),
    .frame_done  (frame_done),
    .exp_product (exp_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 2*N-1; k++) begin
      if (mdl_clr) colreg[k] <= '0;
      else         colreg[k] <= {colreg[k][N-2:0], pp_col[k]};
    end
  end

  function automatic int dep(input int k);
    return (k <= N-1) ? (k + 1) : (2*N - 1 - k);
  endfunction

  // Compressor output: each held bit of column k weighs 2^k.
  function automatic longint dst_val();
    longint s;
    s = 0;
    for (int k = 0; k < 2*N-1; k++)
      for (int j = 0; j < dep(k); j++)
        if (colreg[k][j]) s += (longint'(1) << k);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; the handshake happens on the next posedge.
  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    chk({tag, "_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = N'($urandom);
    in_b = N'($urandom);
  endtask

  // Runs cycles 1..N (SHIFT) and the frame_done cycle N+1 after acceptance.
  // mode: 0 no pattern check, 1 a=b=1 pattern, 2 all-ones pattern, 3 all-zero.
  task automatic body(input int mode, input longint expv, input string tag, input bit hold);
    logic [2*N-2:0] ev;
    logic [2*N-1:0] eprod;
    for (int c = 1; c <= N; c++) begin
      @(negedge clk);
      chk({tag, "_shift_ctl"}, {busy, in_ready, frame_done}, 3'b100);
      if (mode != 0) begin
        ev = '0;
        if (mode == 1 && c == N) ev[0] = 1'b1;
        if (mode == 2)
          for (int k = 0; k < 2*N-1; k++)
            ev[k] = ((c - 1) >= (N - dep(k)));
        chk({tag, "_pp_col"}, pp_col, ev);
      end
      if (hold) begin
        in_valid = 1'b1;
        in_a = N'($urandom);
        in_b = N'($urandom);
      end
    end
    @(negedge clk);
    if (hold) in_valid = 1'b0;
    chk({tag, "_done_ctl"}, {busy, in_ready, frame_done}, 3'b011);
    chk({tag, "_done_pp0"}, pp_col, '0);
    chk({tag, "_dst"}, dst_val(), expv);
`ifdef PP_COL_SERIALIZER_CHECK_EN
    eprod = (2*N)'(expv);
`else
    eprod = '0;
`endif
    chk({tag, "_exp_product"}, exp_product, eprod);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    mdl_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {busy, frame_done, in_ready}, 3'b001);
    chk("rst_pp_col", pp_col, '0);
    chk("rst_exp_product", exp_product, '0);
    rst = 1'b0;
    mdl_clr = 1'b0;
    @(negedge clk);

    // Single frame a=1, b=1
    accept(N'(1), N'(1), "one");
    body(1, 64'd1, "one", 1'b0);
    @(negedge clk);
    chk("one_idle_ctl", {busy, frame_done, in_ready}, 3'b001);
    chk("one_idle_pp", pp_col, '0);

    // All-ones operands
    accept({N{1'b1}}, {N{1'b1}}, "ones");
    body(2, 64'h003F_FFFF_F000_0001, "ones", 1'b0);
    @(negedge clk);

    // Back-to-back: second pair accepted in the DONE cycle
    accept(N'(3), N'(5), "b2b_a");
    body(0, 64'd15, "b2b_a", 1'b0);
    accept(N'(7), N'(9), "b2b_b");
    body(0, 64'd63, "b2b_b", 1'b0);
    @(negedge clk);
    chk("b2b_idle_ctl", {busy, frame_done, in_ready}, 3'b001);

    // in_valid held high with changing operands during SHIFT
    accept(N'(11), N'(13), "hold");
    body(0, 64'd143, "hold", 1'b1);
    @(negedge clk);
    chk("hold_idle_ctl", {busy, frame_done, in_ready}, 3'b001);
    @(negedge clk);
    chk("hold_idle2_ctl", {busy, frame_done, in_ready}, 3'b001);

    // Reset during t=10 of a frame
    accept(N'(32'h5A5A5A5), N'(32'h1234567), "abort");
    for (int c = 1; c <= 11; c++) @(negedge clk);
    chk("abort_pre_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ctl", {busy, frame_done, in_ready}, 3'b001);
    chk("abort_pp_col", pp_col, '0);
    chk("abort_exp_product", exp_product, '0);
    for (int c = 0; c < N + 2; c++) begin
      @(negedge clk);
      chk("abort_no_done", {busy, frame_done}, 2'b00);
    end
    accept(N'(6), N'(7), "after");
    body(0, 64'd42, "after", 1'b0);
    @(negedge clk);

    // a=0: nothing ever driven
    accept(N'(0), N'(32'h7FFFFFF), "zero");
    body(3, 64'd0, "zero", 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
